// File: rtl/pb_timer_pkg.sv
// Shared constants for the PicoBlaze port-mapped timer: register offsets
// inside the 8-port window and bit positions of CTRL and STATUS.
package pb_timer_pkg;

   localparam logic [2:0] OFF_CTRL      = 3'd0;
   localparam logic [2:0] OFF_RELOAD_LO = 3'd1;
   localparam logic [2:0] OFF_RELOAD_HI = 3'd2;
   localparam logic [2:0] OFF_COUNT_LO  = 3'd3;
   localparam logic [2:0] OFF_COUNT_HI  = 3'd4;
   localparam logic [2:0] OFF_STATUS    = 3'd5;
   localparam logic [2:0] OFF_PRESCALE  = 3'd6;
   localparam logic [2:0] OFF_ID        = 3'd7;

   localparam int CTRL_EN          = 0;
   localparam int CTRL_AUTO_RELOAD = 1;
   localparam int CTRL_IRQ_EN      = 2;
   localparam int CTRL_W           = 3;

   localparam int STATUS_EXPIRED   = 0;

   // True when the CPU port address falls inside the block's 8-port window.
   function automatic logic port_hit(input logic [7:0] port_id, input logic [7:0] base);
      return port_id[7:3] == base[7:3];
   endfunction

endpackage

// File: rtl/pb_timer_prescaler.sv
// 8-bit prescaler: counts 0..prescale while enabled and emits a one-cycle
// tick on the terminal value before wrapping to 0.
module pb_timer_prescaler (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       clear,
   input  logic [7:0] prescale,
   output logic       tick
);

   logic [7:0] cnt_q, cnt_d;

   // >= rather than == so that lowering PRESCALE mid-run ticks at once
   // instead of running the counter round through 255.
   assign tick = enable && (cnt_q >= prescale);

   // NOTE: every variable assigned in a combinational block gets a default
   // first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pb_timer_port.sv
// KCPSM6 port-mapped 16-bit down-counter timer with interrupt.
// Build option: define PB_TIMER_SNAPSHOT_EN for an atomic LO-then-HI count read.
module pb_timer_port
   import pb_timer_pkg::*;
#(
   parameter logic [7:0] BASE_ADDR = 8'h10,
   parameter logic [7:0] ID_VALUE  = 8'hA5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] port_id,
   input  logic [7:0] out_port,
   input  logic       write_strobe,
   input  logic       read_strobe,
   output logic [7:0] in_port,
   output logic       interrupt,
   input  logic       interrupt_ack
);

   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [15:0]       reload_q, reload_d;
   logic [7:0]        prescale_q, prescale_d;
   logic [15:0]       count_q, count_d;
   logic              expired_q, expired_d;
   logic              irq_q, irq_d;
   logic [7:0]        in_port_q, in_port_d;

   logic              sel, wr, rd;
   logic [2:0]        off;
   logic              wr_ctrl, start, tick, expire;
   logic [7:0]        count_hi_rd, rdata;

   assign sel = port_hit(port_id, BASE_ADDR);
   assign off = port_id[2:0];
   assign wr  = write_strobe && sel;
   assign rd  = read_strobe && sel;

   assign wr_ctrl = wr && (off == OFF_CTRL);
   // Only a rising EN edge reloads; rewriting EN=1 leaves the count alone.
   assign start   = wr_ctrl && out_port[CTRL_EN] && !ctrl_q[CTRL_EN];
   assign expire  = tick && (count_q == 16'h0000);

   pb_timer_prescaler u_prescaler (
      .clk      (clk),
      .reset    (reset),
      .enable   (ctrl_q[CTRL_EN]),
      .clear    (start),
      .prescale (prescale_q),
      .tick     (tick)
   );

`ifdef PB_TIMER_SNAPSHOT_EN
   logic [7:0] shadow_q, shadow_d;

   assign shadow_d    = (rd && (off == OFF_COUNT_LO)) ? count_q[15:8] : shadow_q;
   assign count_hi_rd = shadow_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         shadow_q <= '0;
      end else begin
         shadow_q <= shadow_d;
      end
   end
`else
   logic unused_rd;

   assign unused_rd   = rd;
   assign count_hi_rd = count_q[15:8];
`endif

   always_comb begin
      ctrl_d     = ctrl_q;
      reload_d   = reload_q;
      prescale_d = prescale_q;
      count_d    = count_q;
      expired_d  = expired_q;
      irq_d      = irq_q;

      if (start) begin
         count_d = reload_q;
      end else if (tick) begin
         if (count_q != 16'h0000) begin
            count_d = count_q - 16'd1;
         end else if (ctrl_q[CTRL_AUTO_RELOAD]) begin
            count_d = reload_q;
         end else begin
            ctrl_d[CTRL_EN] = 1'b0;
         end
      end

      if (wr) begin
         case (off)
            OFF_CTRL:      ctrl_d         = out_port[CTRL_W-1:0];
            OFF_RELOAD_LO: reload_d[7:0]  = out_port;
            OFF_RELOAD_HI: reload_d[15:8] = out_port;
            OFF_PRESCALE:  prescale_d     = out_port;
            OFF_STATUS:    if (out_port[STATUS_EXPIRED]) expired_d = 1'b0;
            default:       ;
         endcase
      end

      // Set sources come last so an expiry beats a same-cycle W1C or ack.
      if (interrupt_ack) begin
         irq_d = 1'b0;
      end
      if (expire) begin
         expired_d = 1'b1;
         if (ctrl_q[CTRL_IRQ_EN]) begin
            irq_d = 1'b1;
         end
      end
   end

   always_comb begin
      rdata = 8'h00;
      case (off)
         OFF_CTRL:      rdata = {{(8-CTRL_W){1'b0}}, ctrl_q};
         OFF_RELOAD_LO: rdata = reload_q[7:0];
         OFF_RELOAD_HI: rdata = reload_q[15:8];
         OFF_COUNT_LO:  rdata = count_q[7:0];
         OFF_COUNT_HI:  rdata = count_hi_rd;
         OFF_STATUS:    rdata = {7'b0, expired_q};
         OFF_PRESCALE:  rdata = prescale_q;
         OFF_ID:        rdata = ID_VALUE;
         default:       rdata = 8'h00;
      endcase
      // Zero when unaddressed so peripherals can be OR-ed onto in_port.
      in_port_d = sel ? rdata : 8'h00;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_q     <= '0;
         reload_q   <= '0;
         prescale_q <= '0;
         count_q    <= '0;
         expired_q  <= 1'b0;
         irq_q      <= 1'b0;
         in_port_q  <= '0;
      end else begin
         ctrl_q     <= ctrl_d;
         reload_q   <= reload_d;
         prescale_q <= prescale_d;
         count_q    <= count_d;
         expired_q  <= expired_d;
         irq_q      <= irq_d;
         in_port_q  <= in_port_d;
      end
   end

   assign in_port   = in_port_q;
   assign interrupt = irq_q;

endmodule

// File: tb/tb_pb_timer_port.sv
// Self-checking bench for pb_timer_port; expected read data is queued when
// each INPUT is issued and compared once the registered in_port appears.
module tb_pb_timer_port;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] port_id;
   logic [7:0] out_port;
   logic       write_strobe;
   logic       read_strobe;
   logic [7:0] in_port;
   logic       interrupt;
   logic       interrupt_ack;

   int checks   = 0;
   int failures = 0;

   string      name_q[$];
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   pb_timer_port #(
      .BASE_ADDR (8'h10),
      .ID_VALUE  (8'hA5)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .port_id       (port_id),
      .out_port      (out_port),
      .write_strobe  (write_strobe),
      .read_strobe   (read_strobe),
      .in_port       (in_port),
      .interrupt     (interrupt),
      .interrupt_ack (interrupt_ack)
   );

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic io_write(input logic [7:0] a, input logic [7:0] d);
      port_id      = a;
      out_port     = d;
      write_strobe = 1'b1;
      cyc();
      write_strobe = 1'b0;
      port_id      = 8'hFF;
   endtask

   // Queues the expectation, then issues an INPUT; data is valid one edge later.
   task automatic io_read(input logic [7:0] a, input string nm, input logic [7:0] ev,
                          output logic [7:0] got);
      name_q.push_back(nm);
      exp_q.push_back(ev);
      port_id     = a;
      read_strobe = 1'b1;
      cyc();
      got         = in_port;
      read_strobe = 1'b0;
      port_id     = 8'hFF;
   endtask

   task automatic sb_pop(output string nm, output logic [7:0] ev);
      nm = name_q.pop_front();
      ev = exp_q.pop_front();
   endtask

   task automatic clear_flags();
      io_write(8'h10, 8'h00);
      io_write(8'h15, 8'h01);
      interrupt_ack = 1'b1;
      cyc();
      interrupt_ack = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] got, ev;
      string nm;
      reset = 1'b1;
      cyc(3);
      reset = 1'b0;
      checks++;
      if (in_port !== 8'h00 || interrupt !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs: in_port=%h interrupt=%b required 00/0", in_port, interrupt);
      end
      io_read(8'h17, "id_off7", 8'hA5, got);
      sb_pop(nm, ev); checks++;
      if (got !== ev) begin failures++; $display("FAIL %s: got=%h required=%h", nm, got, ev); end
      io_read(8'h10, "ctrl_reset", 8'h00, got);
      sb_pop(nm, ev); checks++;
      if (got !== ev) begin failures++; $display("FAIL %s: got=%h required=%h", nm, got, ev); end
      io_read(8'h20, "unselected", 8'h00, got);
      sb_pop(nm, ev); checks++;
      if (got !== ev) begin failures++; $display("FAIL %s: got=%h required=%h", nm, got, ev); end
      io_read(8'h15, "status_reset", 8'h00, got);
      sb_pop(nm, ev); checks++;
      if (got !== ev) begin failures++; $display("FAIL %s: got=%h required=%h", nm, got, ev); end
   endtask

   task automatic test_auto_reload();
      logic [7:0] got, ev;
      string nm;
      io_write(8'h11, 8'h03);
      io_write(8'h12, 8'h00);
      io_write(8'h16, 8'h00);
      io_write(8'h10, 8'h07);
      cyc(3);
      checks++;
      if (interrupt !== 1'b0) begin failures++; $display("FAIL ar_irq_early: interrupt=%b required 0", interrupt); end
      io_read(8'h13, "ar_count_zero", 8'h00, got);
      sb_pop(nm, ev); checks++;
      if (got !== ev) begin failures++; $display("FAIL %s: got=%h required=%h", nm, got, ev); end
      checks++;
      if (interrupt !== 1'b1) begin failures++; $display("FAIL ar_irq_set: interrupt=%b required 1", interrupt); end
      io_read(8'h13, "ar_count_reload", 8'h03, got);
      sb_pop(nm, ev); checks++;
      if (got !== ev) begin failures++; $display("FAIL %s: got=%h required=%h", nm, got, ev); end
      io_read(8'h15, "ar_status_set", 8'h01, got);
      sb_pop(nm, ev); checks++;
      if (got !== ev) begin failures++; $display("FAIL %s: got=%h required=%h", nm, got, ev); end
      port_id       = 8'h15;
      out_port      = 8'h01;
      write_strobe  = 1'b1;
      interrupt_ack = 1'b1;
      cyc();
      write_strobe  = 1'b0;
      interrupt_ack = 1'b0;
      checks++;
      if (interrupt !== 1'b0) begin failures++; $display("FAIL ar_ack_clear: interrupt=%b required 0", interrupt); end
      io_read(8'h15, "ar_w1c", 8'h00, got);
      sb_pop(nm, ev); checks++;
      if (got !== ev) begin failures++; $display("FAIL %s: got=%h required=%h", nm, got, ev); end
      checks++;
      if (interrupt !== 1'b1) begin failures++; $display("FAIL ar_period4: interrupt=%b required 1", interrupt); end
      io_read(8'h15, "ar_status_again", 8'h01, got);
      sb_pop(nm, ev); checks++;
      if (got !== ev) begin failures++; $display("FAIL %s: got=%h required=%h", nm, got, ev); end
   endtask

   task automatic test_collision();
      logic [7:0] got, ev;
      string nm;
      clear_flags();
      io_write(8'h10, 8'h07);
      cyc(4);
      checks++;
      if (interrupt !== 1'b1) begin failures++; $display("FAIL col_first_irq: interrupt=%b required 1", interrupt); end
      cyc(3);
      port_id       = 8'h15;
      out_port      = 8'h01;
      write_strobe  = 1'b1;
      interrupt_ack = 1'b1;
      cyc();
      write_strobe  = 1'b0;
      interrupt_ack = 1'b0;
      port_id       = 8'hFF;
      checks++;
      if (interrupt !== 1'b1) begin failures++; $display("FAIL col_irq_set_wins: interrupt=%b required 1", interrupt); end
      io_read(8'h15, "col_expired_set_wins", 8'h01, got);
      sb_pop(nm, ev); checks++;
      if (got !== ev) begin failures++; $display("FAIL %s: got=%h required=%h", nm, got, ev); end
   endtask

   task automatic test_one_shot();
      logic [7:0] got, ev;
      string nm;
      clear_flags();
      io_write(8'h11, 8'h02);
      io_write(8'h10, 8'h05);
      cyc(3);
      checks++;
      if (interrupt !== 1'b1) begin failures++; $display("FAIL os_irq: interrupt=%b required 1", interrupt); end
      io_read(8'h10, "os_ctrl_en_clr", 8'h04, got);
      sb_pop(nm, ev); checks++;
      if (got !== ev) begin failures++; $display("FAIL %s: got=%h required=%h", nm, got, ev); end
      io_read(8'h13, "os_count_lo", 8'h00, got);
      sb_pop(nm, ev); checks++;
      if (got !== ev) begin failures++; $display("FAIL %s: got=%h required=%h", nm, got, ev); end
      interrupt_ack = 1'b1;
      cyc();
      interrupt_ack = 1'b0;
      checks++;
      if (interrupt !== 1'b0) begin failures++; $display("FAIL os_ack: interrupt=%b required 0", interrupt); end
      io_read(8'h15, "os_status_kept", 8'h01, got);
      sb_pop(nm, ev); checks++;
      if (got !== ev) begin failures++; $display("FAIL %s: got=%h required=%h", nm, got, ev); end
      io_write(8'h15, 8'h01);
      io_read(8'h15, "os_status_w1c", 8'h00, got);
      sb_pop(nm, ev); checks++;
      if (got !== ev) begin failures++; $display("FAIL %s: got=%h required=%h", nm, got, ev); end
      io_read(8'h14, "os_count_hi", 8'h00, got);
      sb_pop(nm, ev); checks++;
      if (got !== ev) begin failures++; $display("FAIL %s: got=%h required=%h", nm, got, ev); end
      checks++;
      if (interrupt !== 1'b0) begin failures++; $display("FAIL os_no_retrigger: interrupt=%b required 0", interrupt); end
   endtask

   task automatic test_prescale();
      logic [7:0] got, ev;
      string nm;
      io_write(8'h16, 8'h04);
      io_write(8'h11, 8'h01);
      io_write(8'h10, 8'h05);
      cyc(9);
      checks++;
      if (interrupt !== 1'b0) begin failures++; $display("FAIL ps_clock9: interrupt=%b required 0", interrupt); end
      cyc();
      checks++;
      if (interrupt !== 1'b1) begin failures++; $display("FAIL ps_clock10: interrupt=%b required 1", interrupt); end
      io_read(8'h15, "ps_status", 8'h01, got);
      sb_pop(nm, ev); checks++;
      if (got !== ev) begin failures++; $display("FAIL %s: got=%h required=%h", nm, got, ev); end
   endtask

   task automatic test_snapshot();
      logic [7:0] got, ev, hi_exp;
      string nm;
`ifdef PB_TIMER_SNAPSHOT_EN
      hi_exp = 8'h01;
`else
      hi_exp = 8'h00;
`endif
      clear_flags();
      io_write(8'h16, 8'h00);
      io_write(8'h11, 8'hFF);
      io_write(8'h12, 8'h01);
      io_write(8'h10, 8'h01);
      io_read(8'h13, "snap_lo", 8'hFF, got);
      sb_pop(nm, ev); checks++;
      if (got !== ev) begin failures++; $display("FAIL %s: got=%h required=%h", nm, got, ev); end
      cyc(256);
      io_read(8'h14, "snap_hi", hi_exp, got);
      sb_pop(nm, ev); checks++;
      if (got !== ev) begin failures++; $display("FAIL %s: got=%h required=%h", nm, got, ev); end
      io_read(8'h13, "snap_live_lo", 8'hFD, got);
      sb_pop(nm, ev); checks++;
      if (got !== ev) begin failures++; $display("FAIL %s: got=%h required=%h", nm, got, ev); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] got, ev;
      string nm;
      io_write(8'h16, 8'h04);
      io_write(8'h10, 8'h00);
      io_write(8'h10, 8'h07);
      cyc(20);
      reset        = 1'b1;
      port_id      = 8'h10;
      out_port     = 8'h07;
      write_strobe = 1'b1;
      cyc();
      reset        = 1'b0;
      write_strobe = 1'b0;
      port_id      = 8'hFF;
      checks++;
      if (interrupt !== 1'b0 || in_port !== 8'h00) begin
         failures++;
         $display("FAIL mid_reset_outputs: interrupt=%b in_port=%h required 0/00", interrupt, in_port);
      end
      io_read(8'h10, "mid_ctrl", 8'h00, got);
      sb_pop(nm, ev); checks++;
      if (got !== ev) begin failures++; $display("FAIL %s: got=%h required=%h", nm, got, ev); end
      io_read(8'h16, "mid_prescale", 8'h00, got);
      sb_pop(nm, ev); checks++;
      if (got !== ev) begin failures++; $display("FAIL %s: got=%h required=%h", nm, got, ev); end
      io_read(8'h12, "mid_reload_hi", 8'h00, got);
      sb_pop(nm, ev); checks++;
      if (got !== ev) begin failures++; $display("FAIL %s: got=%h required=%h", nm, got, ev); end
      io_read(8'h13, "mid_count_lo", 8'h00, got);
      sb_pop(nm, ev); checks++;
      if (got !== ev) begin failures++; $display("FAIL %s: got=%h required=%h", nm, got, ev); end
      io_read(8'h15, "mid_status", 8'h00, got);
      sb_pop(nm, ev); checks++;
      if (got !== ev) begin failures++; $display("FAIL %s: got=%h required=%h", nm, got, ev); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset         = 1'b1;
      port_id       = 8'hFF;
      out_port      = 8'h00;
      write_strobe  = 1'b0;
      read_strobe   = 1'b0;
      interrupt_ack = 1'b0;
      test_reset();
      test_auto_reload();
      test_collision();
      test_one_shot();
      test_prescale();
      test_snapshot();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pb_timer_port.md
Name: pb_timer_port

Overview:
- Port-mapped 16-bit down-counter timer that responds to KCPSM6 (PicoBlaze) port I/O.
- Decodes `port_id`/`write_strobe`/`read_strobe`, supplies `in_port` data and drives the CPU `interrupt` line, which `interrupt_ack` clears.
- Sits beside `cpu` in a top level and is clocked by the system controller's `CLK_OUT`/`RESET_OUT`.
- `in_port` is zero when the block is not addressed, so several peripherals can be OR-combined onto the CPU input port.

Parameters:
- BASE_ADDR, 8'h10, block base port; selected when `port_id[7:3] == BASE_ADDR[7:3]`, offset = `port_id[2:0]`.
- ID_VALUE, 8'hA5, constant returned at offset 7.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- port_id  input  8  CPU port address.
- out_port  input  8  CPU write data.
- write_strobe  input  1  one-cycle write qualifier.
- read_strobe  input  1  one-cycle read qualifier (used only for read side effects).
- in_port  output  8  registered read data to CPU.
- interrupt  output  1  interrupt request to CPU.
- interrupt_ack  input  1  CPU acknowledge.

Behaviour:
- Reset: in_port=0, interrupt=0, CTRL=0, RELOAD=16'h0000, PRESCALE=0, count=0, prescaler=0, expired=0, shadow=0.
- Register map by offset; writes to read-only offsets are ignored:
  - 0 CTRL, RW: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN, bits7:3 read 0.
  - 1 RELOAD_LO, RW.
  - 2 RELOAD_HI, RW.
  - 3 COUNT_LO, R.
  - 4 COUNT_HI, R.
  - 5 STATUS, bit0 EXPIRED; write 1 clears it (W1C).
  - 6 PRESCALE, RW.
  - 7 ID, R.
- Writes take effect on the clock edge where `write_strobe=1`.
- Read path: `in_port` is registered every cycle from the current `port_id`, giving 1-cycle latency. This satisfies KCPSM6 INPUT timing, where `port_id` is stable for 2 cycles. When not selected, `in_port` = 8'h00.
- Start: a write to CTRL with EN going 0->1 loads count<=RELOAD and clears the prescaler. Writing EN=1 while already 1 does not reload.
- Tick: the prescaler counts 0..PRESCALE while EN=1 and emits a one-cycle tick at PRESCALE, then wraps to 0. PRESCALE=0 gives a tick every clock.
- On a tick with EN=1:
  - count!=0: count<=count-1.
  - count==0: EXPIRED<=1.
    - If AUTO_RELOAD=1, count<=RELOAD, giving a period of RELOAD+1 ticks.
    - Else EN<=0 (one-shot) and count stays 0.
- Interrupt: set on the cycle after an expiry event when IRQ_EN=1, and held until `interrupt_ack`.
  - `interrupt_ack` clears `interrupt` only, not EXPIRED.
  - Expiry in the same cycle as ack: set wins.
- Simultaneous events:
  - EXPIRED W1C in the same cycle as expiry: set wins.
  - RELOAD write while running: new value used at the next reload only.
  - Writing EN=0 freezes count and prescaler; interrupt and EXPIRED are held.
- Reset mid-count returns every register to its reset value on the next edge, regardless of strobes.

Optional Feature:
- Macro: PB_TIMER_SNAPSHOT_EN.
- Defined:
  - A read of offset 3 (`read_strobe=1`) latches count[15:8] into an 8-bit shadow.
  - Offset 4 returns the shadow, giving an atomic 16-bit read as LO then HI.
- Undefined: no shadow register; offset 4 returns live count[15:8].

Decomposition:
- Package pb_timer_pkg:
  - offset constants (OFF_CTRL..OFF_ID);
  - CTRL bit indices (CTRL_EN, CTRL_AUTO_RELOAD, CTRL_IRQ_EN);
  - STATUS_EXPIRED index.
- Sub-module pb_timer_prescaler: 8-bit prescale counter.
  - Inputs: clk, reset, enable, clear, prescale.
  - Output: tick.

Test Plan:
- Reset, then INPUT from ports 8'h17 and 8'h10 -> in_port = 8'hA5 one cycle after port_id, then 8'h00. INPUT from 8'h20 -> 8'h00.
- RELOAD=16'h0003, PRESCALE=0, CTRL=8'h07 -> EXPIRED sets after 4 ticks, interrupt rises the next cycle, count reloads to 3. Repeats every 4 clocks.
- One-shot: CTRL=8'h05, RELOAD=2 -> one expiry, then CTRL reads 8'h04 and count stays 0. `interrupt_ack` drops interrupt while STATUS still reads 8'h01. Writing STATUS=8'h01 clears it to 8'h00.
- PRESCALE=8'h04, RELOAD=1 -> expiry at clock 10 after enable.
- Collision: `interrupt_ack` and W1C of STATUS in the same cycle as an expiry -> interrupt stays 1 and EXPIRED stays 1.
- With PB_TIMER_SNAPSHOT_EN, count=16'h01FF counting down: read offset 3 (8'hFF), wait for count 16'h00FE, read offset 4 -> 8'h01. Without the macro, the offset 4 read returns 8'h00.
